seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_detect_param_if.sv | 23 ++
 rtl/sat_counter.sv | 19 +
 rtl/seq_detect_param.sv | 96 +++++++++
 tb/tb_seq_detect_param.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared FSM encoding and pattern-length limits for seq_detect_param
package seq_det_pkg;

  localparam int SEQ_W_MIN = 2;
  localparam int SEQ_W_MAX = 16;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial data, mode, pattern-load and match signals of seq_detect_param
interface seq_detect_param_if #(
  parameter int SEQ_W = 4,
  parameter int CNT_W = 8
);
  logic             i_x;
  logic             i_valid;
  logic             i_overlap;
  logic             i_load;
  logic [SEQ_W-1:0] i_pattern;
  logic             o_seq_detected;
  logic [CNT_W-1:0] o_match_cnt;

  modport master (
    output i_x, i_valid, i_overlap, i_load, i_pattern,
    input  o_seq_detected, o_match_cnt
  );

  modport slave (
    input  i_x, i_valid, i_overlap, i_load, i_pattern,
    output o_seq_detected, o_match_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous active-low reset
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {CNT_W{1'b1}})) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - loadable serial pattern detector, Mealy match flag; SEQ_DETECT_MATCH_CNT_EN adds a match counter
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               SEQ_W       = 4,
  parameter logic [SEQ_W-1:0] DEF_PATTERN = SEQ_W'(4'b1011),
  parameter int               CNT_W       = 8
) (
  input logic               i_clk,
  input logic               i_rst_b,
  seq_detect_param_if.slave bus
);

  localparam int                FILL_W    = $clog2(SEQ_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_W - 2);

  if ((SEQ_W < SEQ_W_MIN) || (SEQ_W > SEQ_W_MAX)) begin : g_bad_seq_w
    $error("seq_detect_param: SEQ_W out of range");
  end

  state_t            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SEQ_W-2:0]  hist_q, hist_d;
  logic [SEQ_W-1:0]  pat_q, pat_d;
  logic [SEQ_W-1:0]  window;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;

  // The candidate window includes the bit presented this cycle, giving zero-latency detection.
  assign window = {hist_q, bus.i_x};
  assign match  = bus.i_valid & ~bus.i_load & (state_q == ST_ARMED) & (window == pat_q);
  assign bus.o_seq_detected = match;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= DEF_PATTERN;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    if (bus.i_load) begin
      pat_d   = bus.i_pattern;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (bus.i_valid) begin
      hist_d = window[SEQ_W-2:0];
      case (state_q)
        ST_FILL: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_LAST) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Non-overlapping mode demands a completely fresh pattern after each hit.
          if (match && !bus.i_overlap) begin
            fill_d  = '0;
            state_d = ST_FILL;
          end
        end
        default: begin
          fill_d  = '0;
          state_d = ST_FILL;
        end
      endcase
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .i_clk   (i_clk),
    .i_rst_b (i_rst_b),
    .i_inc   (match),
    .o_cnt   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

  assign bus.o_match_cnt = match_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param (CNT_W=8 and CNT_W=2 instances)
module tb_seq_detect_param;

  localparam int SEQ_W = 4;

  logic             clk;
  logic             rst_n;
  logic             x;
  logic             valid;
  logic             overlap;
  logic             load;
  logic [SEQ_W-1:0] pattern;

  int errors = 0;
  int checks = 0;

  seq_detect_param_if #(.SEQ_W(SEQ_W), .CNT_W(8)) bus_a ();
  seq_detect_param_if #(.SEQ_W(SEQ_W), .CNT_W(2)) bus_b ();

  assign bus_a.i_x       = x;
  assign bus_a.i_valid   = valid;
  assign bus_a.i_overlap = overlap;
  assign bus_a.i_load    = load;
  assign bus_a.i_pattern = pattern;
  assign bus_b.i_x       = x;
  assign bus_b.i_valid   = valid;
  assign bus_b.i_overlap = overlap;
  assign bus_b.i_load    = load;
  assign bus_b.i_pattern = pattern;

  seq_detect_param #(.CNT_W(8)) dut_a (.i_clk(clk), .i_rst_b(rst_n), .bus(bus_a.slave));
  seq_detect_param #(.CNT_W(2)) dut_b (.i_clk(clk), .i_rst_b(rst_n), .bus(bus_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits received since the last reset, load or non-overlapping hit.
  bit               fresh[$];
  logic [SEQ_W-1:0] m_pat;
  int               m_cnt_a;
  int               m_cnt_b;
  int               bit_idx;
  logic [31:0]      pulse_mask;

  function automatic int exp_cnt(input int c);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  function automatic logic model_det(input logic v, input logic xb, input logic ld);
    logic [SEQ_W-1:0] w;
    int n;
    n = fresh.size();
    if (!v || ld || n < SEQ_W - 1) return 1'b0;
    for (int i = 0; i < SEQ_W - 1; i++) w[SEQ_W-1-i] = fresh[n-(SEQ_W-1)+i];
    w[0] = xb;
    return (w == m_pat);
  endfunction

  task automatic model_reset();
    fresh.delete();
    m_pat   = 4'b1011;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  task automatic model_edge(input logic v, input logic xb, input logic ld,
                            input logic [SEQ_W-1:0] p, input logic det);
    if (ld) begin
      fresh.delete();
      m_pat = p;
    end else if (v) begin
      fresh.push_back(xb);
      if (fresh.size() > SEQ_W) void'(fresh.pop_front());
      if (det) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
        if (!overlap) fresh.delete();
      end
    end
  endtask

  task automatic clear_log();
    bit_idx    = 0;
    pulse_mask = '0;
  endtask

  task automatic step(input logic v, input logic xb, input logic ld, input logic [SEQ_W-1:0] p);
    logic e_det;
    @(negedge clk);
    valid = v; x = xb; load = ld; pattern = p;
    #2;
    e_det = model_det(v, xb, ld);
    checks++;
    if (bus_a.o_seq_detected !== e_det) begin
      errors++;
      $display("FAIL det_a t=%0t got=%b want=%b", $time, bus_a.o_seq_detected, e_det);
    end
    checks++;
    if (bus_b.o_seq_detected !== e_det) begin
      errors++;
      $display("FAIL det_b t=%0t got=%b want=%b", $time, bus_b.o_seq_detected, e_det);
    end
    checks++;
    if (bus_a.o_match_cnt !== 8'(exp_cnt(m_cnt_a))) begin
      errors++;
      $display("FAIL cnt_a t=%0t got=%0d want=%0d", $time, bus_a.o_match_cnt, exp_cnt(m_cnt_a));
    end
    checks++;
    if (bus_b.o_match_cnt !== 2'(exp_cnt(m_cnt_b))) begin
      errors++;
      $display("FAIL cnt_b t=%0t got=%0d want=%0d", $time, bus_b.o_match_cnt, exp_cnt(m_cnt_b));
    end
    if (v && !ld) begin
      bit_idx++;
      if (bus_a.o_seq_detected === 1'b1 && bit_idx < 32) pulse_mask[bit_idx] = 1'b1;
    end
    @(posedge clk);
    model_edge(v, xb, ld, p, e_det);
  endtask

  task automatic run_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 1'b0; load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic check_mask(input string name, input logic [31:0] want);
    checks++;
    if (pulse_mask !== want) begin
      errors++;
      $display("FAIL %s pulse_mask got=%h want=%h", name, pulse_mask, want);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus_a.o_seq_detected !== 1'b0 || bus_b.o_seq_detected !== 1'b0) begin
      errors++;
      $display("FAIL reset_det got=%b%b want=00", bus_a.o_seq_detected, bus_b.o_seq_detected);
    end
    checks++;
    if (bus_a.o_match_cnt !== 8'd0 || bus_b.o_match_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", bus_a.o_match_cnt, bus_b.o_match_cnt);
    end
    do_reset();
  endtask

  task automatic test_overlap();
    do_reset();
    overlap = 1'b1;
    run_bits(16'b1011011, 7);
    check_mask("overlap", 32'h90);
    checks++;
    if (bus_a.o_match_cnt !== 8'(exp_cnt(2))) begin
      errors++;
      $display("FAIL overlap_cnt got=%0d want=%0d", bus_a.o_match_cnt, exp_cnt(2));
    end
  endtask

  task automatic test_non_overlap();
    do_reset();
    overlap = 1'b0;
    run_bits(16'b1011011, 7);
    check_mask("non_overlap", 32'h10);
    checks++;
    if (bus_a.o_match_cnt !== 8'(exp_cnt(1))) begin
      errors++;
      $display("FAIL non_overlap_cnt got=%0d want=%0d", bus_a.o_match_cnt, exp_cnt(1));
    end
  endtask

  task automatic test_stall();
    do_reset();
    overlap = 1'b1;
    run_bits(16'b10, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
    run_bits(16'b11, 2);
    check_mask("stall", 32'h10);
  endtask

  task automatic test_load();
    do_reset();
    overlap = 1'b1;
    run_bits(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 4'b0110);
    run_bits(16'b0110, 4);
    check_mask("load", 32'h80);
  endtask

  task automatic test_async_reset();
    clear_log();
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1011);
    run_bits(16'b101, 3);
    @(negedge clk);
    valid = 1'b1; x = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus_a.o_match_cnt !== 8'd0 || bus_b.o_match_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_rst_cnt got=%0d/%0d want=0/0", bus_a.o_match_cnt, bus_b.o_match_cnt);
    end
    checks++;
    if (bus_a.o_seq_detected !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_det got=%b want=0", bus_a.o_seq_detected);
    end
    @(negedge clk);
    valid = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    run_bits(16'b1, 1);
    run_bits(16'b011, 3);
    check_mask("async_reset", 32'h80);
  endtask

  task automatic test_saturate();
    do_reset();
    overlap = 1'b1;
    run_bits(16'b1011011011011011, 16);
    check_mask("saturate", 32'h12490);
    checks++;
    if (bus_b.o_match_cnt !== 2'(exp_cnt(3))) begin
      errors++;
      $display("FAIL sat_cnt_b got=%0d want=%0d", bus_b.o_match_cnt, exp_cnt(3));
    end
    checks++;
    if (bus_a.o_match_cnt !== 8'(exp_cnt(5))) begin
      errors++;
      $display("FAIL sat_cnt_a got=%0d want=%0d", bus_a.o_match_cnt, exp_cnt(5));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    run_bits(16'hFF, 8);
    check_mask("back_to_back", 32'h1F0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 37 == 0) overlap = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; x = 1'b0; load = 1'b0; overlap = 1'b1; pattern = '0;
    model_reset();
    clear_log();
    test_reset();
    test_overlap();
    test_non_overlap();
    test_stall();
    test_load();
    test_async_reset();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
